pipe_hazard_ctl: RTL and testbench
==================================

Name: pipe_hazard_ctl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates write-enable, hold, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three conditions: load-use data hazards (multi-cycle load latency), taken-branch flushes from the MEM stage, and a variable-latency data memory with timeout.
- Sits beside the decode stage; its bubble output zeroes the WB/M/EX control fields entering ID/EX.

Parameters:
- LU_STALL_CYC, 1, number of bubble cycles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 8, maximum MEM_WAIT cycles before entering the error state (2..255).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_ex_memread  in  1  MemRead bit of the ID/EX memory-control field
- id_ex_rt  in  5  destination rt held in ID/EX (bits 20:16)
- if_id_rs  in  5  rs of the instruction in IF/ID
- if_id_rt  in  5  rt of the instruction in IF/ID
- branch_taken  in  1  branch resolved taken in the MEM stage
- mem_req  in  1  MEM stage is performing a load or store
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  force zero WB/M/EX controls into ID/EX
- ex_mem_flush  out  1  clear EX/MEM control fields
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB
- err  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Register outputs: the state register, LU counter, wait counter, err and stall_cnt are clocked. The control outputs are combinational decodes of state and inputs.
- Reset: with rst_n=0 at a rising edge, state=RUN, both counters=0, err=0, stall_cnt=0.
- Outputs while rst_n=0: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, ex_mem_flush=0, pipe_hold=0.
- Load-use hazard (lu): id_ex_memread=1, id_ex_rt!=0, and id_ex_rt equals if_id_rs or if_id_rt. Register $0 never raises a hazard.
- Default outputs (no condition active): pc_write=1, if_id_write=1, all others 0.
- RUN state, priority order:
  - branch_taken: if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1. Stay in RUN.
  - mem_req & !mem_ready: pipe_hold=1, pc_write=0, if_id_write=0. Go to MEM_WAIT with wait counter=1.
  - lu: pc_write=0, if_id_write=0, id_ex_bubble=1. If LU_STALL_CYC>1, go to LU_STALL with LU counter=1; otherwise stay in RUN.
- LU_STALL state:
  - Outputs as for lu. LU counter increments each cycle.
  - When LU counter==LU_STALL_CYC-1, go to RUN next cycle.
  - branch_taken overrides: apply flush outputs, go to RUN, clear LU counter.
  - mem_req & !mem_ready overrides: go to MEM_WAIT; the LU stall is abandoned and re-detected after the wait.
- MEM_WAIT state:
  - While !mem_ready: pipe_hold=1, pc_write=0, if_id_write=0. Wait counter increments.
  - On mem_ready=1: outputs return to defaults that cycle; next state RUN.
  - branch_taken and lu are ignored in this state.
  - If the wait counter reaches MEM_TIMEOUT with mem_ready=0: go to ERR.
- ERR state:
  - err=1, pipe_hold=1, pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Only rst_n=0 leaves ERR.
- Simultaneous mem_ready and timeout on the same cycle: mem_ready wins, go to RUN.
- stall_cnt increments in any cycle with rst_n=1 and pc_write=0, including ERR. Saturates at 2^CNT_W-1; no wrap.
- Reset mid-stall or mid-wait: next cycle is RUN with default outputs.

Optional Feature:
- Macro: PIPE_HAZARD_CTL_CNT_EN.
- Defined: stall_cnt behaves as described above.
- Undefined: stall_cnt is tied to 0, no counter flops are built, and the port remains present.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rt=5, if_id_rs=5, LU_STALL_CYC=1 -> one cycle of pc_write=0, id_ex_bubble=1; defaults the next cycle; stall_cnt=1.
- $0 immunity: id_ex_memread=1, id_ex_rt=0, if_id_rt=0 -> no stall, pc_write=1.
- Branch priority: branch_taken=1 and lu=1 in the same cycle -> if_id_flush=1, ex_mem_flush=1, pc_write=1; stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> pipe_hold=1 for 3 cycles, then released; state returns to RUN; stall_cnt=3.
- Timeout: MEM_TIMEOUT=8, mem_req=1, mem_ready=0 held -> err=1 after 8 cycles and stays 1 with mem_ready=1; rst_n=0 for one edge clears err and restores RUN.
- Multi-cycle LU: LU_STALL_CYC=3, hazard present -> 3 bubble cycles; branch_taken on the 2nd cycle -> flush that cycle, RUN next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
// Pipeline sequencing controller: load-use stalls, MEM-stage branch flushes, memory wait/timeout.
// Define PIPE_HAZARD_CTL_CNT_EN to build the saturating stall counter; otherwise stall_cnt reads 0.
module pipe_hazard_ctl #(
   parameter int LU_STALL_CYC = 1,
   parameter int MEM_TIMEOUT  = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_ex_memread,
   input  logic [4:0]       id_ex_rt,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_flush,
   output logic             pipe_hold,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, ERR} state_t;

   localparam logic [2:0] LU_LAST    = 3'(LU_STALL_CYC - 1);
   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [2:0] luCnt_q, luCnt_d;
   logic [7:0] waitCnt_q, waitCnt_d;
   logic       err_q;
   logic       loadUse;
   logic       memMiss;

   // Register $0 is hardwired to zero, so it can never carry a load-use dependency.
   assign loadUse = id_ex_memread && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
   assign memMiss = mem_req && !mem_ready;
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RUN;
         luCnt_q   <= '0;
         waitCnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         luCnt_q   <= luCnt_d;
         waitCnt_q <= waitCnt_d;
         err_q     <= (state_d == ERR);
      end
   end

   always_comb begin
      state_d      = state_q;
      luCnt_d      = luCnt_q;
      waitCnt_d    = waitCnt_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_flush = 1'b0;
      pipe_hold    = 1'b0;
      if (!rst_n) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end else begin
         unique case (state_q)
            RUN, LU_STALL: begin
               if (branch_taken) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  ex_mem_flush = 1'b1;
                  state_d      = RUN;
                  luCnt_d      = '0;
               end else if (memMiss) begin
                  pipe_hold   = 1'b1;
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  state_d     = MEM_WAIT;
                  waitCnt_d   = 8'd1;
                  luCnt_d     = '0;
               end else if ((state_q == LU_STALL) || loadUse) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  // An ongoing stall finishes its count even if the hazard inputs change.
                  if (state_q == LU_STALL) begin
                     if (luCnt_q == LU_LAST) begin
                        state_d = RUN;
                        luCnt_d = '0;
                     end else begin
                        luCnt_d = luCnt_q + 3'd1;
                     end
                  end else if (LU_STALL_CYC > 1) begin
                     state_d = LU_STALL;
                     luCnt_d = 3'd1;
                  end
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state_d   = RUN;
                  waitCnt_d = '0;
               end else begin
                  pipe_hold   = 1'b1;
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  waitCnt_d   = waitCnt_q + 8'd1;
                  if (waitCnt_d == WAIT_LIMIT) begin
                     state_d = ERR;
                  end
               end
            end
            ERR: begin
               pipe_hold    = 1'b1;
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
            end
            default: state_d = RUN;
         endcase
      end
   end

`ifdef PIPE_HAZARD_CTL_CNT_EN
   logic [CNT_W-1:0] stallCnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt_q <= '0;
      end else if (!pc_write && (stallCnt_q != {CNT_W{1'b1}})) begin
         stallCnt_q <= stallCnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stallCnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: two instances (LU_STALL_CYC=1 and 3) share stimulus;
// a cycle-level reference model pushes expectations that a negedge monitor pops and compares.
module tb_pipe_hazard_ctl;

   localparam int TIMEOUT = 8;

   typedef struct packed {
      logic [6:0]  ctl;
      logic [15:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_ex_memread = 1'b0;
   logic [4:0] id_ex_rt = '0;
   logic [4:0] if_id_rs = '0;
   logic [4:0] if_id_rt = '0;
   logic       branch_taken = 1'b0;
   logic       mem_req = 1'b0;
   logic       mem_ready = 1'b0;

   logic        pcW1, ifW1, ifF1, bub1, exF1, hold1, err1;
   logic        pcW3, ifW3, ifF3, bub3, exF3, hold3, err3;
   logic [15:0] cnt1, cnt3;

   int   total = 0;
   int   bad = 0;
   int   cycle = 0;
   exp_t q1[$];
   exp_t q3[$];

   // Reference model state per instance: index 0 = LU_STALL_CYC 1, index 1 = LU_STALL_CYC 3.
   int luLeft[2]   = '{0, 0};
   int waited[2]   = '{0, 0};
   bit errf[2]     = '{0, 0};
   int stalls[2]   = '{0, 0};
   int luParam[2]  = '{1, 3};

   always #5 clk = ~clk;

   pipe_hazard_ctl #(.LU_STALL_CYC(1), .MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pcW1), .if_id_write(ifW1),
      .if_id_flush(ifF1), .id_ex_bubble(bub1), .ex_mem_flush(exF1), .pipe_hold(hold1),
      .err(err1), .stall_cnt(cnt1));

   pipe_hazard_ctl #(.LU_STALL_CYC(3), .MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pcW3), .if_id_write(ifW3),
      .if_id_flush(ifF3), .id_ex_bubble(bub3), .ex_mem_flush(exF3), .pipe_hold(hold3),
      .err(err3), .stall_cnt(cnt3));

   function automatic logic [15:0] cntExp(input int n);
`ifdef PIPE_HAZARD_CTL_CNT_EN
      return 16'(n);
`else
      return 16'd0 + 16'(n & 0);
`endif
   endfunction

   // Advance the model one cycle: expected outputs come from the state before the edge.
   task automatic modelStep(input int k, input bit rs, input bit rd, input logic [4:0] exRt,
                            input logic [4:0] idRs, input logic [4:0] idRt, input bit br,
                            input bit req, input bit rdy, output exp_t e);
      bit pc, ifw, fl, bub, exf, hold, hz;
      hz  = rd && (exRt != 0) && ((exRt == idRs) || (exRt == idRt));
      pc  = 1; ifw = 1; fl = 0; bub = 0; exf = 0; hold = 0;
      e.cnt    = cntExp(stalls[k]);
      e.ctl[0] = errf[k];
      if (!rs) begin
         pc = 0; ifw = 0; bub = 1;
         luLeft[k] = 0; waited[k] = 0; errf[k] = 0; stalls[k] = 0;
      end else if (errf[k]) begin
         hold = 1; pc = 0; ifw = 0; bub = 1;
      end else if (waited[k] > 0) begin
         if (rdy) begin
            waited[k] = 0;
         end else begin
            hold = 1; pc = 0; ifw = 0;
            waited[k]++;
            if (waited[k] == TIMEOUT) begin
               errf[k] = 1;
               waited[k] = 0;
            end
         end
      end else if (br) begin
         fl = 1; bub = 1; exf = 1; luLeft[k] = 0;
      end else if (req && !rdy) begin
         hold = 1; pc = 0; ifw = 0; waited[k] = 1; luLeft[k] = 0;
      end else if (luLeft[k] > 0) begin
         pc = 0; ifw = 0; bub = 1; luLeft[k]--;
      end else if (hz) begin
         pc = 0; ifw = 0; bub = 1; luLeft[k] = luParam[k] - 1;
      end
      if (rs && !pc && stalls[k] < 65535) stalls[k]++;
      e.ctl[6:1] = {pc, ifw, fl, bub, exf, hold};
   endtask

   task automatic applyStimulus(input bit rs, input bit rd, input logic [4:0] exRt,
                                input logic [4:0] idRs, input logic [4:0] idRt, input bit br,
                                input bit req, input bit rdy);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rs; id_ex_memread = rd; id_ex_rt = exRt; if_id_rs = idRs; if_id_rt = idRt;
      branch_taken = br; mem_req = req; mem_ready = rdy;
      cycle++;
      modelStep(0, rs, rd, exRt, idRs, idRt, br, req, rdy, e);
      q1.push_back(e);
      modelStep(1, rs, rd, exRt, idRs, idRt, br, req, rdy, e);
      q3.push_back(e);
   endtask

   task automatic checkOutput(input string name, input exp_t e, input logic [6:0] gotCtl,
                              input logic [15:0] gotCnt);
      total++;
      if (gotCtl !== e.ctl) begin
         bad++;
         $display("[TB] FAIL %s ctl cycle=%0d got=%b want=%b (pc,ifw,flush,bub,exf,hold,err)",
                  name, cycle, gotCtl, e.ctl);
      end
      total++;
      if (gotCnt !== e.cnt) begin
         bad++;
         $display("[TB] FAIL %s stall_cnt cycle=%0d got=%0d want=%0d", name, cycle, gotCnt, e.cnt);
      end
   endtask

   // Monitor: the controller presents a decision every cycle, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t m;
      if (q1.size() > 0) begin
         m = q1.pop_front();
         checkOutput("lu1", m, {pcW1, ifW1, ifF1, bub1, exF1, hold1, err1}, cnt1);
      end
      if (q3.size() > 0) begin
         m = q3.pop_front();
         checkOutput("lu3", m, {pcW3, ifW3, ifF3, bub3, exF3, hold3, err3}, cnt3);
      end
   end

   initial begin
      int bias;
      $display("[TB] directed scenarios");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      // load-use on rs
      applyStimulus(1, 1, 5'd5, 5'd5, 5'd1, 0, 0, 0);
      repeat (4) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      // register $0 never stalls
      applyStimulus(1, 1, 5'd0, 5'd3, 5'd0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      // branch beats load-use
      applyStimulus(1, 1, 5'd5, 5'd5, 5'd5, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      // three wait cycles then ready
      repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
      repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      // timeout into ERR, sticky through mem_ready, cleared by one reset edge
      repeat (10) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
      repeat (2) applyStimulus(1, 1, 5'd2, 5'd2, 5'd0, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      // multi-cycle load-use interrupted by a branch on its second cycle
      applyStimulus(1, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
      repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      // load-use stall abandoned by a memory miss, then resumed
      applyStimulus(1, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(1, 1, 5'd4, 5'd4, 5'd0, 1, 0, 1);
      repeat (4) applyStimulus(1, 1, 5'd4, 5'd0, 5'd4, 0, 0, 0);

      $display("[TB] randomized traffic");
      bias = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) bias = (bias == 50) ? 12 : 50;
         applyStimulus($urandom_range(0, 59) != 0, 1'($urandom),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 99) < bias);
      end

      @(negedge clk);
      #1;
      total++;
      if (q1.size() != 0 || q3.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain got=%0d/%0d want=0/0 pending", q1.size(), q3.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
